// File: rtl/bus_pkg.sv
// Shared definitions for the bus transfer sequencer.
//   state_e : sequencer states (IDLE, SETUP, LATCH, HOLD, DONE)
//   clog2   : ceiling log2 used for index and counter widths
//   max3    : largest of three timing parameters, sizes the down-counter
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LATCH = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int p = 1; p < value; p = p * 2) begin
      res = res + 1;
    end
    return res;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/bus_onehot_dec.sv
// Index-to-one-hot decoder for the bus enable strobes.
//   en     : when low the output is all zero
//   idx    : register index to select
//   onehot : N-bit vector with at most one bit set (bit idx when en is high)
module bus_onehot_dec #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          en,
  input  logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  // Compare against every position so an out-of-range index yields zero.
  always_comb begin
    onehot = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      onehot[i] = en && (idx == IW'(i));
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Register-to-register transfer sequencer for the shared 4-bit register bus.
// Drives per-register oe/ie strobes through SETUP -> LATCH -> HOLD -> DONE.
// In the two-register system oe[0]/oe[1]/ie[0]/ie[1] connect to the bus
// block's R0oe/R1oe/R0ie/R1ie.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   req_valid : transfer request present
//   req_src   : source register index
//   req_dst   : destination register index
//   req_ready : controller can accept a request (registered)
//   oe        : one-hot/zero source output enables (registered)
//   ie        : one-hot/zero destination input enables (registered)
//   busy      : transfer in progress (registered)
//   done      : one-cycle pulse on transfer completion (registered)
//   err       : one-cycle pulse when a request is rejected (registered)
module bus_xfer_ctrl
  import bus_pkg::*;
#(
  parameter int NREG      = 2,
  parameter int SETUP_CYC = 2,
  parameter int LATCH_CYC = 3,
  parameter int HOLD_CYC  = 2,
  localparam int IW = (clog2(NREG) > 1) ? clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [IW-1:0]   req_src,
  input  logic [IW-1:0]   req_dst,
  output logic            req_ready,
  output logic [NREG-1:0] oe,
  output logic [NREG-1:0] ie,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int CW = clog2(max3(SETUP_CYC, LATCH_CYC, HOLD_CYC) + 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LATCH_LD = CW'(LATCH_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  state_e          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [IW-1:0]   src_r, dst_r, src_s, dst_s;
  logic            req_ready_r, busy_r, done_r, err_r, err_s;
  logic [NREG-1:0] oe_r, ie_r, oe_dec_s, ie_dec_s;
  logic            oe_en_s, ie_en_s, req_ok_s;

  assign req_ok_s = (32'(req_src) < 32'(NREG)) && (32'(req_dst) < 32'(NREG)) &&
                    (req_src != req_dst);

  // Next-state, counter and latched-index logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    src_s   = src_r;
    dst_s   = dst_r;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // req_ready_r is low for the first cycle after reset, which gates accept.
        if (req_valid && req_ready_r) begin
          if (req_ok_s) begin
            state_s = SETUP;
            cnt_s   = SETUP_LD;
            src_s   = req_src;
            dst_s   = req_dst;
          end else begin
            err_s   = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_s = LATCH;
          cnt_s   = LATCH_LD;
        end else begin
          cnt_s   = cnt_r - CW'(1);
        end
      end
      LATCH: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_s = HOLD;
          cnt_s   = HOLD_LD;
        end else begin
          cnt_s   = cnt_r - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_s = DONE;
          cnt_s   = {CW{1'b0}};
        end else begin
          cnt_s   = cnt_r - CW'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered strobes line up with it.
  always_comb begin
    oe_en_s = (state_s == SETUP) || (state_s == LATCH) || (state_s == HOLD);
    ie_en_s = (state_s == LATCH);
  end

  bus_onehot_dec #(.N(NREG), .IW(IW)) u_oe_dec (
    .en     (oe_en_s),
    .idx    (src_s),
    .onehot (oe_dec_s)
  );

  bus_onehot_dec #(.N(NREG), .IW(IW)) u_ie_dec (
    .en     (ie_en_s),
    .idx    (dst_s),
    .onehot (ie_dec_s)
  );

  // State, counter, latched indices and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      src_r       <= {IW{1'b0}};
      dst_r       <= {IW{1'b0}};
      oe_r        <= {NREG{1'b0}};
      ie_r        <= {NREG{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      req_ready_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      src_r       <= src_s;
      dst_r       <= dst_s;
      oe_r        <= oe_dec_s;
      ie_r        <= ie_dec_s;
      busy_r      <= oe_en_s;
      done_r      <= (state_s == DONE);
      err_r       <= err_s;
      req_ready_r <= (state_s == IDLE);
    end
  end

  assign req_ready = req_ready_r;
  assign oe        = oe_r;
  assign ie        = ie_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: doc/bus_xfer_ctrl.md
Name: bus_xfer_ctrl

Overview:
- Transfer sequencer that sits directly upstream of the shared 4-bit register bus block and drives its per-register output-enable (oe) and input-enable (ie) strobes.
- Accepts register-to-register move requests over a valid/ready handshake.
- Runs the fixed sequence: drive source → latch destination → hold → release. At most one source ever drives the bus.
- Replaces hand-sequenced enable waveforms with a single registered FSM.

Parameters:
- NREG, 2, number of bus registers (2..16)
- SETUP_CYC, 2, cycles source oe is asserted before destination ie rises (>=1)
- LATCH_CYC, 3, cycles destination ie is held high (>=1)
- HOLD_CYC, 2, cycles source oe stays high after ie falls (>=1)

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  transfer request present
- req_src  in  IW  source register index; IW = max(1, clog2(NREG))
- req_dst  in  IW  destination register index
- req_ready  out  1  controller can accept a request
- oe  out  NREG  one-hot/zero source output enables to the bus block
- ie  out  NREG  one-hot/zero destination input enables to the bus block
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when a transfer completes
- err  out  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counters=0, oe=0, ie=0, busy=0, done=0, err=0, req_ready=0 while rst low. req_ready=1 from the first cycle after rst deasserts.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SETUP, LATCH, HOLD, DONE.
- IDLE:
  - req_ready=1; accept when req_valid & req_ready at a clock edge.
  - A valid request (src<NREG, dst<NREG, src!=dst) latches src/dst → SETUP. oe[src]=1 and busy=1 from the next cycle.
  - An invalid request is consumed with err=1 for exactly one cycle; state stays IDLE and oe/ie are unchanged (0).
- SETUP: oe[src]=1, ie=0 for SETUP_CYC cycles → LATCH.
- LATCH: oe[src]=1, ie[dst]=1 for LATCH_CYC cycles → HOLD.
- HOLD: ie=0, oe[src]=1 for HOLD_CYC cycles → DONE.
- DONE: oe=0, ie=0, done=1, busy=0, one cycle → IDLE.
- req_ready=0 in SETUP through DONE. A req_valid held during a transfer is not accepted until IDLE.
- Timing from the accept edge (cycle 0), defaults:
  - oe high cycles 1–7
  - ie high cycles 3–5
  - done in cycle 8
  - req_ready high again in cycle 9
  - Total period is SETUP_CYC+LATCH_CYC+HOLD_CYC+2 cycles per transfer.
- Invariants:
  - popcount(oe)<=1 and popcount(ie)<=1 at all times.
  - ie[i] is never high unless some oe[j], j!=i, is high.
  - ie rises strictly after oe and falls strictly before oe.
- Counter: single down-counter, width clog2(max(SETUP_CYC,LATCH_CYC,HOLD_CYC)+1). It is loaded with (N-1) on entry to each timed state; the state advances when the count reaches 0.
- req_src/req_dst changing after accept has no effect; the latched indices are used.
- Reset mid-transfer: oe/ie drop to 0 immediately (asynchronously). No done pulse. Controller returns to IDLE.

Decomposition:
- Shared package bus_pkg: the state enumeration (IDLE, SETUP, LATCH, HOLD, DONE) and the index-width function clog2.
- Sub-module: bus_onehot_dec (index + enable → NREG-bit one-hot). Instantiated twice, once for oe and once for ie.
- Top-level integration maps oe[0]/oe[1]/ie[0]/ie[1] onto the bus block's R0oe/R1oe/R0ie/R1ie.

Test Plan:
- Reset and idle: hold rst=0 for 2 cycles, then release → oe=0, ie=0, busy=0, done=0, err=0 throughout reset; req_ready=1 on the first cycle after release.
- Forward move: req src=0, dst=1, defaults → oe=01 cycles 1–7, ie=10 cycles 3–5, done pulse at cycle 8, req_ready=1 at cycle 9. With the bus block attached and R0=4'hA, R1 reads 4'hA afterward.
- Reverse move: req src=1, dst=0 issued immediately at cycle 9 → identical timing shifted by 9 cycles, oe=10, ie=01; back-to-back transfers show no overlap between them.
- Illegal requests: src=dst=1 → err=1 for one cycle, oe/ie stay 0, state IDLE. With NREG=3, src=3 → err=1 for one cycle, oe/ie stay 0, state IDLE.
- Held request while busy: keep req_valid=1 with src=0, dst=1 → exactly one transfer per 9-cycle period; req_ready low cycles 1–8 of each period.
- Reset mid-operation: assert rst=0 in cycle 4 (in LATCH) → oe/ie fall within the same cycle without waiting for a clock edge; no done pulse; after release, a new transfer completes normally. Assertion checks popcount(oe)<=1 and popcount(ie)<=1 across all tests.
